// File: rtl/p6_multishift_seq.sv
// Multi-cycle shifter for the P6 datapath: one 1-bit pass/LSL/LSR/ASR step per clock,
// with a start/busy/done handshake toward the control FSM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_SHIFT | applying one step per edge, count down to terminal count 1
// S_DONE  | one-cycle done pulse; result stable; may accept a new start
module p6_multishift_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    step_val = dout;
    case (op_q)
      2'b01:   step_val = {dout[WIDTH-2:0], 1'b0};
      2'b10:   step_val = {1'b0, dout[WIDTH-1:1]};
      2'b11:   step_val = {dout[WIDTH-1], dout[WIDTH-1:1]};
      default: step_val = dout;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      op_q  <= 2'b00;
      count <= '0;
      dout  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            dout  <= din;
            op_q  <= op;
            count <= amount;
            // zero-length requests skip SHIFT so done lands one cycle after start
            if (amount == '0 || op == 2'b00) state <= S_DONE;
            else                             state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          dout  <= step_val;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_p6_multishift_seq.sv
// Self-checking bench for p6_multishift_seq: directed plan cases plus randomized
// operations (with noise on inputs while shifting) against an arithmetic shift model.
module tb_p6_multishift_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  p6_multishift_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .amount (amount),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
    logic [15:0] r;
    case (o)
      2'b01:   r = d << a;
      2'b10:   r = d >> a;
      2'b11:   r = $signed(d) >>> a;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [3:0] a);
    return (o == 2'b00 || a == 4'd0) ? 1 : int'(a) + 1;
  endfunction

  // Called at the falling edge of cycle 0 with start already driven for (o,a,d).
  // Returns at the falling edge of the done cycle.
  task automatic track(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d,
                       input bit noise, input bit chain,
                       input logic [1:0] no, input logic [3:0] na, input logic [15:0] nd);
    int lat;
    logic [15:0] exp;
    lat = latency(o, a);
    exp = model(o, a, d);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(c < lat));
      chk("done", 32'(done), 32'(c == lat));
      if (c == lat) chk("dout", 32'(dout), 32'(exp));
      if (c < lat) begin
        if (noise) begin
          start  = 1'($urandom_range(0, 1));
          op     = 2'($urandom);
          amount = 4'($urandom);
          din    = 16'($urandom);
        end else begin
          start = 1'b0;
        end
      end else if (chain) begin
        start = 1'b1; op = no; amount = na; din = nd;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    start = 1'b1; op = o; amount = a; din = d;
  endtask

  task automatic run_single(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
    logic [15:0] exp;
    exp = model(o, a, d);
    issue(o, a, d);
    track(o, a, d, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("hold_dout", 32'(dout), 32'(exp));
    end
  endtask

  initial begin
    logic [1:0]  co, no;
    logic [3:0]  ca, na;
    logic [15:0] cd, nd;
    bit          chain;

    // reset held with start asserted
    resetn = 1'b0; start = 1'b1; op = 2'b01; amount = 4'd3; din = 16'hAAAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
    end
    start = 1'b0; resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    run_single(2'b01, 4'd4,  16'h00F1);
    run_single(2'b11, 4'd15, 16'h8000);
    run_single(2'b10, 4'd15, 16'h8000);
    run_single(2'b11, 4'd1,  16'h7FFE);
    run_single(2'b01, 4'd0,  16'h1234);
    run_single(2'b00, 4'd7,  16'hBEEF);
    run_single(2'b01, 4'd15, 16'hFFFF);

    // start during SHIFT ignored (noisy inputs), then back-to-back accept in done cycle
    issue(2'b10, 4'd3, 16'hF000);
    track(2'b10, 4'd3, 16'hF000, 1'b1, 1'b1, 2'b01, 4'd2, 16'h0003);
    track(2'b01, 4'd2, 16'h0003, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);

    // reset asserted mid-operation
    issue(2'b01, 4'd8, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_hold_done", 32'(done), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_rel_done", 32'(done), 32'd0);
    run_single(2'b01, 4'd1, 16'h0001);

    // randomized operations with optional back-to-back chaining
    co = 2'($urandom); ca = 4'($urandom); cd = 16'($urandom);
    issue(co, ca, cd);
    for (int i = 0; i < 60; i++) begin
      no = 2'($urandom); na = 4'($urandom); nd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) na = 4'd0;
      chain = 1'($urandom);
      track(co, ca, cd, 1'b1, chain, no, na, nd);
      if (!chain) begin
        @(negedge clk);
        chk("rnd_idle_busy", 32'(busy), 32'd0);
        chk("rnd_idle_done", 32'(done), 32'd0);
        chk("rnd_hold_dout", 32'(dout), 32'(model(co, ca, cd)));
        start = 1'b1; op = no; amount = na; din = nd;
      end
      co = no; ca = na; cd = nd;
    end
    track(co, ca, cd, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
